// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer sitting beside the EX stage.
// One start pulse launches a 32-step shift-add multiply or restoring divide.
// The 64-bit result lands in HI/LO 33 clocks after start. The unit stalls the
// pipeline for any later mul/div or HI/LO read that arrives while it is busy.
// Optional feature macro: MULDIV_SIGNED_EN. When it is defined, op[0] selects
// signed MULT/DIV. When it is undefined, all ops are unsigned and no
// abs/negate logic is built.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hilo_rd,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  // acc : product upper half during multiply, partial remainder during divide
  // low : multiplier (product low bits shift in) or dividend/quotient
  // opb : multiplicand or divisor, held for the whole operation
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] low;
  logic [WIDTH-1:0] opb;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

`ifdef MULDIV_SIGNED_EN
  logic neg_q;   // quotient/product must be negated (operand signs differ)
  logic neg_r;   // remainder must be negated (dividend was negative)
  logic a_neg;
  logic b_neg;

  assign a_neg = op[0] & A[WIDTH-1];
  assign b_neg = op[0] & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;
`else
  // op[0] only distinguishes signed variants, which this build treats as unsigned
  logic unused_op0;
  assign unused_op0 = op[0];
  assign a_mag = A;
  assign b_mag = B;
`endif

  assign busy  = (state != IDLE);
  assign stall = busy & (start | hilo_rd);

  // One multiply step: conditional add into the upper half, then shift
  // {carry, acc, low} right by one.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   mul_top;
  logic [WIDTH-1:0] mul_acc_next;
  logic [WIDTH-1:0] mul_low_next;

  assign mul_sum      = {1'b0, acc} + {1'b0, opb};
  assign mul_top      = low[0] ? mul_sum : {1'b0, acc};
  assign mul_acc_next = mul_top[WIDTH:1];
  assign mul_low_next = {mul_top[0], low[WIDTH-1:1]};

  // One restoring-divide step. The shifted remainder is always below
  // 2*divisor, so a WIDTH+1 bit trial difference is enough to read its sign.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] div_acc_next;
  logic [WIDTH-1:0] div_low_next;

  assign div_shift    = {acc, low[WIDTH-1]};
  assign div_trial    = div_shift - {1'b0, opb};
  assign div_ok       = ~div_trial[WIDTH];
  assign div_acc_next = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_low_next = {low[WIDTH-2:0], div_ok};

  // Final result with sign correction applied to the raw magnitudes
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  // Form the architectural HI/LO values from the finished accumulators
  always_comb begin
    res_hi = acc;
    res_lo = low;
`ifdef MULDIV_SIGNED_EN
    if (is_div) begin
      if (neg_q) res_lo = -low;
      if (neg_r) res_hi = -acc;
    end else if (neg_q) begin
      {res_hi, res_lo} = -{acc, low};
    end
`endif
  end

  // Sequencer FSM. HI/LO, done and dbz are registered and change only here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      acc    <= '0;
      low    <= '0;
      opb    <= '0;
      HI     <= '0;
      LO     <= '0;
      done   <= 1'b0;
      dbz    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      dbz  <= 1'b0;
      if (flush) begin
        // Abort: HI/LO are untouched and no done pulse is produced
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              is_div <= op[1];
              acc    <= '0;
              cnt    <= '0;
              if (op[1]) begin
                low <= a_mag;   // dividend
                opb <= b_mag;   // divisor
              end else begin
                low <= b_mag;   // multiplier
                opb <= a_mag;   // multiplicand
              end
`ifdef MULDIV_SIGNED_EN
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
`endif
              state <= RUN;
            end
          end
          RUN: begin
            if (is_div) begin
              acc <= div_acc_next;
              low <= div_low_next;
            end else begin
              acc <= mul_acc_next;
              low <= mul_low_next;
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) state <= FIN;
          end
          FIN: begin
            HI    <= res_hi;
            LO    <= res_lo;
            done  <= 1'b1;
            dbz   <= is_div & (opb == '0);
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed-vector bench for muldiv_seq. Stimulus pushes the
// expected HI/LO/dbz of each accepted operation into a queue. A monitor pops
// and compares whenever the unit pulses done. The bench also checks reset,
// stall, flush and the mid-operation reset. Signed vectors are selected by
// MULDIV_SIGNED_EN.
module tb_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         hilo_rd;
  logic         flush;
  logic         busy;
  logic         stall;
  logic         done;
  logic         dbz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(a_in), .B(b_in),
    .hilo_rd(hilo_rd), .flush(flush), .busy(busy), .stall(stall),
    .done(done), .dbz(dbz), .HI(hi), .LO(lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: each done pulse is one transaction
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("dbz", dbz, e.dbz);
        $display("txn hi=%h lo=%h dbz=%0d (exp hi=%h lo=%h dbz=%0d)",
                 hi, lo, dbz, e.hi, e.lo, e.dbz);
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    e.dbz = ed;
    q.push_back(e);
  endtask

  // Issue one operation from IDLE and follow it to completion
  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh,
                        input logic [W-1:0] el, input logic ed);
    int n;
    push_exp(eh, el, ed);
    op = o; a_in = a; b_in = b; start = 1'b1;
    tick;
    start = 1'b0;
    chk({name, "_busy"}, busy, 1);
    n = 1;
    while (busy && n < 100) begin
      tick;
      if (busy) n++;
    end
    chk({name, "_busy_cycles"}, n, 33);
    chk({name, "_done"}, done, 1);
    hilo_rd = 1'b1;
    #1;
    chk({name, "_mfhi_nostall"}, stall, 0);
    hilo_rd = 1'b0;
    tick;
    chk({name, "_pulse_end"}, {done, dbz}, 0);
  endtask

  initial begin
    int n;
    int stall_bad;
    int done_cnt;
    rst = 1'b1; start = 1'b0; op = 2'b00; a_in = '0; b_in = '0;
    hilo_rd = 1'b0; flush = 1'b0;
    repeat (3) tick;
    chk("rst_ctrl", {busy, stall, done, dbz}, 0);
    chk("rst_hilo", {hi, lo}, 0);
    rst = 1'b0;
    tick;

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0);
    run_op("multu_shift", 2'b00, 32'h1234_5678, 32'h10, 32'd1, 32'h2345_6780, 1'b0);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("divu_zero", 2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
    run_op("divu_by1", 2'b10, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_small", 2'b10, 32'd7, 32'd9, 32'd7, 32'd0, 1'b0);
`ifdef MULDIV_SIGNED_EN
    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("mult_m3_5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_op("div_m5_0", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'd1, 1'b1);
`else
    run_op("mult_unsigned", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'd4, 32'hFFFF_FFF1, 1'b0);
    run_op("div_unsigned", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0);
`endif

    // Hazard: HI/LO read and a second start arrive while busy
    push_exp(32'd0, 32'd12, 1'b0);
    op = 2'b00; a_in = 32'd3; b_in = 32'd4; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    hilo_rd = 1'b1;
    #1;
    chk("haz_rd_stall", stall, 1);
    tick; tick;
    op = 2'b00; a_in = 32'd5; b_in = 32'd6; start = 1'b1;
    #1;
    chk("haz_start_stall", stall, 1);
    n = 0; stall_bad = 0;
    while (busy && n < 100) begin
      if (!stall) stall_bad++;
      tick;
      n++;
    end
    chk("haz_stall_held", stall_bad, 0);
    chk("haz_released", {busy, stall}, 0);
    chk("haz_first_done", done, 1);
    push_exp(32'd0, 32'd30, 1'b0);
    tick;
    start = 1'b0; hilo_rd = 1'b0;
    chk("haz_second_accepted", busy, 1);
    n = 1;
    while (busy && n < 100) begin
      tick;
      if (busy) n++;
    end
    chk("haz_second_cycles", n, 33);
    tick;

    // Flush at RUN cycle 10: no done, HI/LO keep 0:30
    op = 2'b00; a_in = 32'd7; b_in = 32'd8; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_idle", {busy, done}, 0);
    done_cnt = 0;
    repeat (40) begin
      tick;
      if (done) done_cnt++;
    end
    chk("flush_no_done", done_cnt, 0);
    chk("flush_hilo_kept", {hi, lo}, {32'd0, 32'd30});

    // Flush beats start in the same cycle
    start = 1'b1; flush = 1'b1;
    tick;
    start = 1'b0; flush = 1'b0;
    chk("flush_over_start", busy, 0);

    // Asynchronous reset mid-RUN clears everything immediately
    op = 2'b00; a_in = 32'hFFFF_FFFF; b_in = 32'hFFFF_FFFF; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    rst = 1'b1;
    #1;
    chk("async_rst_ctrl", {busy, done, dbz, stall}, 0);
    chk("async_rst_hilo", {hi, lo}, 0);
    tick;
    rst = 1'b0;
    tick;
    run_op("after_rst", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    repeat (3) tick;
    chk("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
